bm_match_accum_stage: RTL and testbench

//   Downstream consumer of the match-primitive arithmetic stage. Each beat

---
 rtl/bm_match_accum_stage.sv | 148 ++++++++++++++
 tb/tb_bm_match_accum_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bm_match_accum_stage.sv
// -----------------------------------------------------------------------------
// bm_match_accum_stage
//
// Purpose:
//   Frame accumulator that sits after the match-primitive MAC outputs. On each
//   accepted beat the three unsigned lanes are added together, and that lane
//   sum is added into a running frame total. After ACC_LEN beats the total is
//   presented on a valid/ready output. It stays there until the downstream
//   stage takes it. No beats are accepted while a finished total is waiting.
//
// Optional feature (compile-time macro):
//   ACCUM_SATURATE_EN - defined  : any carry clamps the frame total to
//                                  2^ACC_W-1 for the rest of the frame
//                       undefined: the total wraps modulo 2^ACC_W
//   In both modes out_ovf reports that the frame overflowed ACC_W bits.
//
// Ports:
//   clock      in   1        single clock, all logic on posedge
//   reset      in   1        synchronous, active-high
//   in_valid   in   1        input beat present
//   in_ready   out  1        stage can accept a beat (state != HOLD)
//   in_d0..2   in   DATA_W   unsigned lanes
//   out_valid  out  1        frame total present
//   out_ready  in   1        downstream accepts the total
//   out_sum    out  ACC_W    frame total
//   out_ovf    out  1        frame total exceeded ACC_W bits
// -----------------------------------------------------------------------------
module bm_match_accum_stage #(
  parameter int DATA_W  = 18,
  parameter int ACC_LEN = 4,
  parameter int ACC_W   = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_d0,
  input  logic [DATA_W-1:0] in_d1,
  input  logic [DATA_W-1:0] in_d2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf_acc;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_sum;
  logic               r_out_ovf;

  logic               w_accept;
  logic               w_last;
  logic               w_frame_start;
  logic [ACC_W-1:0]   w_lane_sum;
  logic [ACC_W-1:0]   w_base;
  logic [ACC_W:0]     w_sum_full;
  logic               w_carry;
  logic               w_ovf_nxt;
  logic [ACC_W-1:0]   w_nxt;

  assign in_ready      = (r_state != HOLD);
  assign w_accept      = in_valid & in_ready;
  assign w_last        = (r_cnt == CNT_W'(ACC_LEN - 1));
  assign w_frame_start = (r_cnt == '0);

  // ACC_W >= DATA_W+2 guarantees three lanes never overflow the lane sum.
  assign w_lane_sum = ACC_W'(in_d0) + ACC_W'(in_d1) + ACC_W'(in_d2);

  // The first beat of a frame starts from zero. This does not depend on the
  // accumulator having been cleared beforehand.
  assign w_base     = w_frame_start ? '0 : r_acc;
  assign w_sum_full = {1'b0, w_base} + {1'b0, w_lane_sum};
  assign w_carry    = w_sum_full[ACC_W];
  assign w_ovf_nxt  = (w_frame_start ? 1'b0 : r_ovf_acc) | w_carry;

`ifdef ACCUM_SATURATE_EN
  // Once the frame has overflowed, the total is pinned at full scale.
  assign w_nxt = w_ovf_nxt ? '1 : w_sum_full[ACC_W-1:0];
`else
  assign w_nxt = w_sum_full[ACC_W-1:0];
`endif

  // NOTE: state and data registers use non-blocking assignments. Every flop
  // then samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: next-state is defaulted to the current state before the case.
  // Paths that do not assign it therefore cannot infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_last ? HOLD : ACCUM;
      ACCUM:   if (w_accept && w_last) w_state_nxt = HOLD;
      HOLD:    if (r_out_valid && out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: every datapath register is reset, not only the control state.
  // This means out_sum/out_ovf read as zero after reset, and a frame that was
  // cut off by reset leaves nothing behind.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf_acc   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_out_sum   <= w_nxt;
        r_out_ovf   <= w_ovf_nxt;
        r_out_valid <= 1'b1;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_ovf_acc   <= 1'b0;
      end else begin
        r_acc       <= w_nxt;
        r_cnt       <= r_cnt + 1'b1;
        r_ovf_acc   <= w_ovf_nxt;
      end
    end else if (r_out_valid && out_ready) begin
      // out_sum/out_ovf keep their value; only the next frame replaces them.
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_bm_match_accum_stage.sv
// -----------------------------------------------------------------------------
// tb_bm_match_accum_stage
//
// Drives two instances with the same stimulus: ACC_W=24 (default) and ACC_W=20,
// where overflow is reachable. A frame-level model gathers accepted beats and
// then folds the plain integer total into each width. Every cycle, the DUT
// outputs are compared with that model. Directed sequences pin known totals.
// -----------------------------------------------------------------------------
module tb_bm_match_accum_stage;

  localparam int DATA_W  = 18;
  localparam int ACC_LEN = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_d0, in_d1, in_d2;
  logic              out_ready;

  logic              in_ready_a, out_valid_a, out_ovf_a;
  logic [23:0]       out_sum_a;
  logic              in_ready_b, out_valid_b, out_ovf_b;
  logic [19:0]       out_sum_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  bm_match_accum_stage #(.DATA_W(DATA_W), .ACC_LEN(ACC_LEN), .ACC_W(24)) dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_ovf(out_ovf_a)
  );

  bm_match_accum_stage #(.DATA_W(DATA_W), .ACC_LEN(ACC_LEN), .ACC_W(20)) dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_ovf(out_ovf_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit     m_started = 0;
  bit     m_hold    = 0;
  int     m_n       = 0;
  longint m_total   = 0;
  longint m_sum24   = 0, m_sum20 = 0;
  logic   m_ovf24   = 0, m_ovf20 = 0;

  // Folds an exact integer frame total into a w-bit result.
  function automatic void fold(input longint tot, input int w,
                               output longint s, output logic o);
    longint lim;
    lim = longint'(1) << w;
    o   = (tot >= lim);
`ifdef ACCUM_SATURATE_EN
    s = o ? lim - 1 : tot;
`else
    s = tot % lim;
`endif
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_started = 1;
      m_hold = 0; m_n = 0; m_total = 0;
      m_sum24 = 0; m_sum20 = 0; m_ovf24 = 0; m_ovf20 = 0;
    end else if (m_hold) begin
      if (out_ready) m_hold = 0;
    end else if (in_valid) begin
      m_total += longint'(in_d0) + longint'(in_d1) + longint'(in_d2);
      m_n++;
      if (m_n == ACC_LEN) begin
        fold(m_total, 24, m_sum24, m_ovf24);
        fold(m_total, 20, m_sum20, m_ovf20);
        m_hold  = 1;
        m_n     = 0;
        m_total = 0;
      end
    end
  end

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (m_started) begin
      check("a_in_ready",  in_ready_a,  !m_hold);
      check("a_out_valid", out_valid_a, m_hold);
      check("a_out_sum",   out_sum_a,   m_sum24);
      check("a_out_ovf",   out_ovf_a,   m_ovf24);
      check("b_in_ready",  in_ready_b,  !m_hold);
      check("b_out_valid", out_valid_b, m_hold);
      check("b_out_sum",   out_sum_b,   m_sum20);
      check("b_out_ovf",   out_ovf_b,   m_ovf20);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Presents a beat and returns 1 ns after the edge that accepts it.
  // in_valid is left high so that the caller can run beats back-to-back.
  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [DATA_W-1:0] c);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_d0 = a; in_d1 = b; in_d2 = c;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (in_ready_a) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout at %0t: in_ready never rose", $time);
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_d0 = DATA_W'($urandom); in_d1 = DATA_W'($urandom); in_d2 = DATA_W'($urandom);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (out_valid_a) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL wait_valid_timeout at %0t: out_valid never rose", $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_lane();
    case ($urandom % 3)
      0:       return DATA_W'($urandom_range(0, 15));
      1:       return DATA_W'($urandom);
      default: return 18'h3FFFF - DATA_W'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog at %0t: bench did not finish", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_d0 = '0; in_d1 = '0; in_d2 = '0;

    // 1: reset for 2 cycles
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_sum",   out_sum_a,   0);
    check("rst_out_ovf",   out_ovf_a,   0);
    check("rst_in_ready",  in_ready_a,  1);

    // 2: back-to-back beats, out_ready=1
    send(1, 2, 3); send(4, 5, 6); send(7, 8, 9); send(10, 11, 12);
    check("t2_out_valid", out_valid_a, 1);
    check("t2_out_sum",   out_sum_a,   78);
    check("t2_out_ovf",   out_ovf_a,   0);
    idle(1);
    check("t2_valid_drop", out_valid_a, 0);
    check("t2_in_ready",   in_ready_a,  1);
    idle(2);

    // 3: back-pressure while in_valid is held high
    out_ready = 1'b0;
    send(1, 2, 3); send(4, 5, 6); send(7, 8, 9); send(10, 11, 12);
    in_d0 = 1; in_d1 = 1; in_d2 = 1;
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_sum",   out_sum_a,   78);
      check("t3_hold_ready", in_ready_a,  0);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    wait_valid();
    check("t3_next_sum", out_sum_a, 12);
    idle(3);

    // 4: in_valid toggles, junk on invalid cycles
    idle(1); send(1, 2, 3);
    idle(1); send(4, 5, 6);
    idle(1); send(7, 8, 9);
    idle(1); send(10, 11, 12);
    check("t4_out_sum", out_sum_a, 78);
    idle(3);

    // 5: all lanes at full scale; only the 20-bit instance overflows
    for (int k = 0; k < 4; k++) send(18'h3FFFF, 18'h3FFFF, 18'h3FFFF);
    check("t5_a_sum", out_sum_a, 3145716);
    check("t5_a_ovf", out_ovf_a, 0);
`ifdef ACCUM_SATURATE_EN
    check("t5_b_sum", out_sum_b, 1048575);
`else
    check("t5_b_sum", out_sum_b, 1048564);
`endif
    check("t5_b_ovf", out_ovf_b, 1);
    idle(3);

    // 6: reset mid-frame discards the partial frame
    send(5, 5, 5); send(5, 5, 5);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) send(1, 0, 0);
    check("t6_out_sum", out_sum_a, 4);
    check("t6_out_ovf", out_ovf_a, 0);
    idle(3);

    // Randomised traffic: gaps, back-pressure, occasional reset
    for (int c = 0; c < 1500; c++) begin
      reset     = ($urandom % 300) == 0;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_d0 = rnd_lane(); in_d1 = rnd_lane(); in_d2 = rnd_lane();
      @(posedge clock); #1;
    end
    reset = 1'b0;
    out_ready = 1'b1;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
